// File: rtl/sd_byte_fifo.sv
// Byte-wide synchronous FIFO with 512-byte sector framing, fed by the SD card reader.
// Optional SD_BYTE_FIFO_BLOCK_COUNT_EN adds a 16-bit count of completed sectors.
module sd_byte_fifo #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned BLOCK_BYTES = 512
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  block_done
`ifdef SD_BYTE_FIFO_BLOCK_COUNT_EN
    ,
    output logic [15:0]           block_count
`endif
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned BlkW  = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
    localparam logic [BlkW-1:0]     BlkLast   = BlkW'(BLOCK_BYTES - 1);
    localparam logic [ADDR_WIDTH:0] FullCount = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [BlkW-1:0]       blk_cnt_q, blk_cnt_d;
    logic                  block_done_q, block_done_d;
    logic                  push_acc, pop_acc;

    assign empty = (count_q == '0);
    assign full  = (count_q == FullCount);

    // A push into a full FIFO still lands when a pop frees the oldest slot the same cycle.
    assign push_acc = push & (~full | pop);
    assign pop_acc  = pop & ~empty;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        overflow_d   = overflow_q | (push & ~push_acc);
        underflow_d  = underflow_q | (pop & ~pop_acc);
        blk_cnt_d    = blk_cnt_q;
        block_done_d = 1'b0;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (blk_cnt_q == BlkLast) begin
                blk_cnt_d    = '0;
                block_done_d = 1'b1;
            end else begin
                blk_cnt_d = blk_cnt_q + 1'b1;
            end
        end

        if (pop_acc) begin
            rd_ptr_d   = rd_ptr_q + 1'b1;
            data_out_d = mem_q[rd_ptr_q];
        end

        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            blk_cnt_q    <= '0;
            block_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            blk_cnt_q    <= blk_cnt_d;
            block_done_q <= block_done_d;
        end
    end

    // Storage has no reset; clearing the pointers makes old contents unreachable.
    always_ff @(posedge clock) begin
        if (push_acc && !reset) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out   = data_out_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;
    assign block_done = block_done_q;

`ifdef SD_BYTE_FIFO_BLOCK_COUNT_EN
    logic [15:0] block_count_q, block_count_d;

    always_comb begin
        block_count_d = block_count_q;
        if (block_done_d) begin
            block_count_d = block_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            block_count_q <= '0;
        end else begin
            block_count_q <= block_count_d;
        end
    end

    assign block_count = block_count_q;
`endif

endmodule

// File: tb/tb_sd_byte_fifo.sv
// Self-checking bench for sd_byte_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_sd_byte_fifo;

    localparam int Depth = 1024;
    localparam int Block = 512;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       push;
    logic       pop;
    logic [7:0] data_out;
    logic       empty;
    logic       full;
    logic [10:0] count;
    logic       overflow;
    logic       underflow;
    logic       block_done;
`ifdef SD_BYTE_FIFO_BLOCK_COUNT_EN
    logic [15:0] block_count;
`endif

    sd_byte_fifo #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (10),
        .BLOCK_BYTES(512)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .data_in   (data_in),
        .push      (push),
        .pop       (pop),
        .data_out  (data_out),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .block_done(block_done)
`ifdef SD_BYTE_FIFO_BLOCK_COUNT_EN
        ,
        .block_count(block_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_ovf;
    logic       m_unf;
    logic       m_bdone;
    int         m_accepted;
    int         m_blocks;
    int         n_assert;
    int         n_fail;
    int         n_bdone_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic p, input logic [7:0] d, input logic po);
        bit do_push, do_pop;
        if (r) begin
            q.delete();
            m_dout     = 8'h00;
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            m_bdone    = 1'b0;
            m_accepted = 0;
            m_blocks   = 0;
        end else begin
            do_pop  = po && (q.size() > 0);
            do_push = p && ((q.size() < Depth) || po);
            if (do_pop) m_dout = q.pop_front();
            if (do_push) q.push_back(d);
            if (p && !do_push) m_ovf = 1'b1;
            if (po && !do_pop) m_unf = 1'b1;
            m_bdone = 1'b0;
            if (do_push) begin
                m_accepted++;
                if (m_accepted % Block == 0) begin
                    m_bdone = 1'b1;
                    m_blocks++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == Depth));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("block_done", 32'(block_done), 32'(m_bdone));
`ifdef SD_BYTE_FIFO_BLOCK_COUNT_EN
        chk("block_count", 32'(block_count), 32'(m_blocks % 65536));
`endif
    endtask

    task automatic cyc(input logic r, input logic p, input logic [7:0] d, input logic po);
        reset   = r;
        push    = p;
        data_in = d;
        pop     = po;
        @(posedge clock);
        model_step(r, p, d, po);
        #1;
        if (block_done === 1'b1) n_bdone_seen++;
        check_all();
    endtask

    initial begin
        int bd_before;
        reset   = 1'b1;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = 8'h00;
        n_assert     = 0;
        n_fail       = 0;
        n_bdone_seen = 0;
        model_step(1'b1, 1'b0, 8'h00, 1'b0);

        // Reset then idle
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_data_out", 32'(data_out), 32'h00);

        // 512 bytes 0x00..0xFF twice, then drain
        bd_before = n_bdone_seen;
        for (int i = 0; i < Block; i++) cyc(1'b0, 1'b1, 8'(i), 1'b0);
        chk("blk_pulse_after_512", 32'(block_done), 32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        chk("blk_pulse_one_cycle", 32'(block_done), 32'd0);
        for (int i = 0; i < Block; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1);
            chk("drain_order", 32'(data_out), 32'(i % 256));
        end
        chk("blk_pulse_count", 32'(n_bdone_seen - bd_before), 32'd1);
        chk("drain_count", 32'(count), 32'd0);

        // 1025 pushes with no pops: last one dropped
        for (int i = 0; i < Depth + 1; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_count", 32'(count), 32'd1024);
        chk("fill_overflow", 32'(overflow), 32'd1);

        // Full with simultaneous push 0xA5 and pop: first pop returns oldest byte
        cyc(1'b0, 1'b1, 8'hA5, 1'b1);
        chk("full_pp_count", 32'(count), 32'd1024);
        for (int i = 0; i < Depth - 1; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("wrap_a5", 32'(data_out), 32'hA5);

        // Empty with simultaneous push 0x3C and pop
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'h3C, 1'b1);
        chk("empty_pp_count", 32'(count), 32'd1);
        chk("empty_pp_underflow", 32'(underflow), 32'd1);
        chk("empty_pp_dout_hold", 32'(data_out), 32'h00);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("empty_pp_3c", 32'(data_out), 32'h3C);

        // Mid-block reset: push in the reset cycle must be ignored
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
        cyc(1'b1, 1'b1, 8'h77, 1'b1);
        chk("midreset_count", 32'(count), 32'd0);
        bd_before = n_bdone_seen;
        for (int i = 0; i < Block - 1; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
        chk("midreset_no_early_blk", 32'(n_bdone_seen - bd_before), 32'd0);
        cyc(1'b0, 1'b1, 8'($urandom), 1'b0);
        chk("midreset_blk", 32'(block_done), 32'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                8'($urandom),
                ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0);
        end
        while (q.size() > 0) cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("final_empty", 32'(empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
